// File: rtl/pcm_bank_router.sv
// pcm_bank_router: steers byte reads from a PCM sample engine to one of NBANK
// SDRAM slot ports, with a one-entry read cache, zero-fill for out-of-range
// banks and a per-fetch timeout.
// Ports: CLK96/RESET96 clock and sync active-high reset; flush drops the cache;
// req_rd/req_addr request in, req_dout/req_valid completion out; busy = not
// idle; slot_cs/slot_addr/slot_ok/slot_dout per-slot SDRAM ports;
// timeout_err is a sticky abort flag.
module pcm_bank_router #(
  parameter int NBANK    = 3,
  parameter int BANK_AW  = 22,
  parameter int ADDR_W   = 24,
  parameter int TIMEOUT  = 1023,
  parameter int CACHE_EN = 1
) (
  input  logic                     CLK96,
  input  logic                     RESET96,
  input  logic                     flush,
  input  logic                     req_rd,
  input  logic [ADDR_W-1:0]        req_addr,
  output logic [7:0]               req_dout,
  output logic                     req_valid,
  output logic                     busy,
  output logic [NBANK-1:0]         slot_cs,
  output logic [NBANK*BANK_AW-1:0] slot_addr,
  input  logic [NBANK-1:0]         slot_ok,
  input  logic [NBANK*8-1:0]       slot_dout,
  output logic                     timeout_err
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, HIT, OOR, FETCH} state_t;

  state_t                     state_q, state_d;
  logic [ADDR_W-1:0]          addr_q, addr_d;
  logic [CW-1:0]              cnt_q, cnt_d;
  logic [NBANK-1:0]           slot_cs_q, slot_cs_d;
  logic [NBANK*BANK_AW-1:0]   slot_addr_q, slot_addr_d;
  logic [7:0]                 req_dout_q, req_dout_d;
  logic                       req_valid_q, req_valid_d;
  logic                       timeout_err_q, timeout_err_d;
  logic                       cache_valid_q, cache_valid_d;
  logic [ADDR_W-1:0]          cache_addr_q, cache_addr_d;
  logic [7:0]                 cache_data_q, cache_data_d;

  logic [ADDR_W-BANK_AW-1:0]  bank;
  logic [BANK_AW-1:0]         off;
  logic                       ok_sel;
  logic [7:0]                 dout_sel;
  logic                       hit;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    cnt_d         = cnt_q;
    slot_cs_d     = slot_cs_q;
    slot_addr_d   = slot_addr_q;
    req_dout_d    = req_dout_q;
    req_valid_d   = 1'b0;
    timeout_err_d = timeout_err_q;
    cache_valid_d = cache_valid_q & ~flush;
    cache_addr_d  = cache_addr_q;
    cache_data_d  = cache_data_q;

    bank = req_addr[ADDR_W-1:BANK_AW];
    off  = req_addr[BANK_AW-1:0];

    // slot_cs_q is one-hot during FETCH, so masking by it selects the bank
    ok_sel   = |(slot_ok & slot_cs_q);
    dout_sel = '0;
    for (int unsigned k = 0; k < NBANK; k++) begin
      if (slot_cs_q[k]) dout_sel = dout_sel | slot_dout[k*8 +: 8];
    end

    hit = (CACHE_EN != 0) && cache_valid_q && !flush && (req_addr == cache_addr_q);

    case (state_q)
      IDLE: begin
        if (req_rd) begin
          addr_d = req_addr;
          cnt_d  = '0;
          if (hit) begin
            state_d = HIT;
          end else if (32'(bank) >= $unsigned(NBANK)) begin
            state_d = OOR;
          end else begin
            state_d   = FETCH;
            slot_cs_d = '0;
            for (int unsigned k = 0; k < NBANK; k++) begin
              if (32'(bank) == k) begin
                slot_cs_d[k]                    = 1'b1;
                slot_addr_d[k*BANK_AW +: BANK_AW] = off;
              end
            end
          end
        end
      end
      HIT: begin
        req_valid_d = 1'b1;
        req_dout_d  = cache_data_q;
        state_d     = IDLE;
      end
      OOR: begin
        req_valid_d = 1'b1;
        req_dout_d  = 8'h00;
        state_d     = IDLE;
      end
      FETCH: begin
        // cnt_q == 0 marks the first FETCH cycle, where OK may be stale
        if (cnt_q != '0 && ok_sel) begin
          req_valid_d = 1'b1;
          req_dout_d  = dout_sel;
          slot_cs_d   = '0;
          state_d     = IDLE;
          if (CACHE_EN != 0 && !flush) begin
            cache_valid_d = 1'b1;
            cache_addr_d  = addr_q;
            cache_data_d  = dout_sel;
          end
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          req_valid_d   = 1'b1;
          req_dout_d    = 8'h00;
          slot_cs_d     = '0;
          timeout_err_d = 1'b1;
          state_d       = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK96) begin
    if (RESET96) begin
      state_q       <= IDLE;
      addr_q        <= '0;
      cnt_q         <= '0;
      slot_cs_q     <= '0;
      slot_addr_q   <= '0;
      req_dout_q    <= '0;
      req_valid_q   <= 1'b0;
      timeout_err_q <= 1'b0;
      cache_valid_q <= 1'b0;
      cache_addr_q  <= '0;
      cache_data_q  <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      cnt_q         <= cnt_d;
      slot_cs_q     <= slot_cs_d;
      slot_addr_q   <= slot_addr_d;
      req_dout_q    <= req_dout_d;
      req_valid_q   <= req_valid_d;
      timeout_err_q <= timeout_err_d;
      cache_valid_q <= cache_valid_d;
      cache_addr_q  <= cache_addr_d;
      cache_data_q  <= cache_data_d;
    end
  end

  assign req_dout    = req_dout_q;
  assign req_valid   = req_valid_q;
  assign busy        = (state_q != IDLE);
  assign slot_cs     = slot_cs_q;
  assign slot_addr   = slot_addr_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_pcm_bank_router.sv
module tb_pcm_bank_router;

  localparam int NB = 3;
  localparam int AW = 22;
  localparam int TO = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            req_rd = 1'b0;
  logic [23:0]     req_addr = '0;
  logic [7:0]      req_dout;
  logic            req_valid;
  logic            busy;
  logic [NB-1:0]   slot_cs;
  logic [NB*AW-1:0] slot_addr;
  logic [NB-1:0]   slot_ok;
  logic [NB*8-1:0] slot_dout;
  logic            timeout_err;

  int total = 0;
  int bad = 0;
  int resp_lat = 3;
  int n [NB];

  always #5 clk = ~clk;

  pcm_bank_router #(
    .NBANK(NB), .BANK_AW(AW), .ADDR_W(24), .TIMEOUT(TO), .CACHE_EN(1)
  ) dut (
    .CLK96(clk), .RESET96(rst), .flush(flush), .req_rd(req_rd), .req_addr(req_addr),
    .req_dout(req_dout), .req_valid(req_valid), .busy(busy), .slot_cs(slot_cs),
    .slot_addr(slot_addr), .slot_ok(slot_ok), .slot_dout(slot_dout),
    .timeout_err(timeout_err)
  );

  // Sample ROM contents seen through every slot.
  function automatic logic [7:0] mem(input int k, input logic [21:0] o);
    return o[7:0] ^ o[15:8] ^ {2'b00, o[21:16]} ^ 8'(k * 17) ^ 8'hA4;
  endfunction

  // SDRAM slot model: idle slots show random OK/data; a selected slot shows a
  // stale OK with wrong data in its first cycle, then real data after resp_lat.
  initial begin
    for (int k = 0; k < NB; k++) n[k] = 0;
  end
  always @(negedge clk) begin
    for (int k = 0; k < NB; k++) begin
      if (slot_cs[k]) begin
        n[k] = n[k] + 1;
        if (n[k] == 1) begin
          slot_ok[k] = 1'b1;
          slot_dout[k*8 +: 8] = ~mem(k, slot_addr[k*AW +: AW]);
        end else if (n[k] >= resp_lat) begin
          slot_ok[k] = 1'b1;
          slot_dout[k*8 +: 8] = mem(k, slot_addr[k*AW +: AW]);
        end else begin
          slot_ok[k] = 1'b0;
          slot_dout[k*8 +: 8] = ~mem(k, slot_addr[k*AW +: AW]);
        end
      end else begin
        n[k] = 0;
        slot_ok[k] = 1'($urandom_range(0, 1));
        slot_dout[k*8 +: 8] = 8'($urandom);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_req(input string tag, input logic [23:0] a, input logic fl,
                        input logic [7:0] exp_d, input int exp_lat,
                        input logic [NB-1:0] exp_cs);
    int got;
    int b;
    got = 0;
    b = int'(a[23:22]);
    @(negedge clk);
    req_addr = a;
    req_rd   = 1'b1;
    flush    = fl;
    @(negedge clk);
    req_rd = 1'b0;
    flush  = 1'b0;
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    chk({tag, ".cs"}, 32'(slot_cs), 32'(exp_cs));
    if (exp_cs != '0) chk({tag, ".saddr"}, 32'(slot_addr[b*AW +: AW]), 32'(a[21:0]));
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      chk({tag, ".onehot"}, 32'($onehot0(slot_cs)), 32'd1);
      if (req_valid) begin
        got = c;
        break;
      end
    end
    chk({tag, ".lat"}, 32'(got), 32'(exp_lat));
    chk({tag, ".data"}, 32'(req_dout), 32'(exp_d));
    @(negedge clk);
    chk({tag, ".pulse"}, 32'(req_valid), 32'd0);
    chk({tag, ".csoff"}, 32'(slot_cs), 32'd0);
    chk({tag, ".idle"}, 32'(busy), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [23:0] a;
    logic [23:0] last_a;
    logic        fl;
    int          lat;
    int          bk;
    logic        m_valid;
    logic [23:0] m_addr;
    logic [7:0]  m_data;
    logic        m_err;
    logic [7:0]  ed;
    int          el;
    logic [NB-1:0] ecs;

    repeat (3) @(negedge clk);
    chk("rst.valid", 32'(req_valid), 32'd0);
    chk("rst.dout", 32'(req_dout), 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.cs", 32'(slot_cs), 32'd0);
    chk("rst.saddr", 32'(|slot_addr), 32'd0);
    chk("rst.err", 32'(timeout_err), 32'd0);
    rst = 1'b0;

    resp_lat = 3;
    do_req("fetch1", 24'h400010, 1'b0, 8'hA5, 3, 3'b010);
    do_req("hit", 24'h400010, 1'b0, 8'hA5, 1, 3'b000);
    do_req("flush", 24'h400010, 1'b1, 8'hA5, 3, 3'b010);
    do_req("oor", 24'hC00000, 1'b0, 8'h00, 1, 3'b000);

    resp_lat = 100;
    do_req("tmo", 24'h000123, 1'b0, 8'h00, TO, 3'b001);
    chk("tmo.err", 32'(timeout_err), 32'd1);
    resp_lat = 2;
    do_req("after_tmo", 24'h800456, 1'b0, mem(2, 22'h000456), 2, 3'b100);
    chk("tmo.sticky", 32'(timeout_err), 32'd1);

    // reset while slot 2 is being fetched
    resp_lat = 100;
    @(negedge clk);
    req_addr = 24'h800777;
    req_rd   = 1'b1;
    @(negedge clk);
    req_rd = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst.cs_before", 32'(slot_cs), 32'b100);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst.cs", 32'(slot_cs), 32'd0);
    chk("midrst.busy", 32'(busy), 32'd0);
    chk("midrst.valid", 32'(req_valid), 32'd0);
    chk("midrst.err", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("midrst.nopulse", 32'(req_valid), 32'd0);
    end
    resp_lat = 2;
    do_req("midrst.miss", 24'h800456, 1'b0, mem(2, 22'h000456), 2, 3'b100);

    // randomized phase against a request-level model
    do_reset();
    m_valid = 1'b0;
    m_addr  = '0;
    m_data  = '0;
    m_err   = 1'b0;
    last_a  = 24'h000000;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 2) == 0) a = last_a;
      else a = {2'($urandom_range(0, 3)), 14'h0, 8'($urandom_range(0, 7))};
      fl  = ($urandom_range(0, 4) == 0);
      lat = ($urandom_range(0, 9) == 0) ? 20 : $urandom_range(2, 6);
      bk  = int'(a[23:22]);
      resp_lat = lat;
      if (m_valid && !fl && a == m_addr) begin
        ed = m_data; el = 1; ecs = '0;
      end else begin
        if (fl) m_valid = 1'b0;
        if (bk >= NB) begin
          ed = 8'h00; el = 1; ecs = '0;
        end else begin
          ecs = NB'(1) << bk;
          if (lat <= TO) begin
            ed = mem(bk, a[21:0]); el = lat;
            m_valid = 1'b1; m_addr = a; m_data = ed;
          end else begin
            ed = 8'h00; el = TO; m_err = 1'b1;
          end
        end
      end
      do_req("rand", a, fl, ed, el, ecs);
      chk("rand.err", 32'(timeout_err), 32'(m_err));
      last_a = a;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
